reg_write_arbiter: RTL and testbench
====================================

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, data width of each register-file write.
REQ-002 Parameter NUM_REGS, default 32, number of architectural registers; address width AW = $clog2(NUM_REGS).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset; asserted (0) clears all state immediately, independent of clk.
REQ-005 alu_valid  in  1  ALU writeback request.
REQ-006 alu_ready  out  1  ALU request granted this cycle.
REQ-007 alu_rd  in  AW  ALU destination register.
REQ-008 alu_data  in  WIDTH  ALU writeback value.
REQ-009 lsu_valid  in  1  load-unit writeback request.
REQ-010 lsu_ready  out  1  load-unit request granted this cycle.
REQ-011 lsu_rd  in  AW  load destination register.
REQ-012 lsu_data  in  WIDTH  load writeback value.
REQ-013 rsv_en  in  1  issue stage reserves a destination register.
REQ-014 rsv_rd  in  AW  register being reserved.
REQ-015 busy  out  NUM_REGS  scoreboard; bit i = register i has a pending write.
REQ-016 wr_en  out  1  register-file write enable (registered).
REQ-017 wr_addr  out  AW  register-file write address (registered).
REQ-018 wr_data  out  WIDTH  register-file write data (registered).

Function
REQ-019 Handshake: transfer occurs on a requester in a cycle where its valid and ready are both 1 at the rising edge.
REQ-020 alu_ready and lsu_ready are combinational from the valids and the priority state; at most one is 1 in any cycle.
REQ-021 Only one valid high: that requester gets ready=1 the same cycle (zero-cycle grant).
REQ-022 Both valid: grant the requester not granted at the most recent handshake (round-robin); last-granted state updates on every handshake.
REQ-023 Neither valid: both readies 0, last-granted state unchanged.
REQ-024 A requester with valid=1 and ready=0 holds valid, rd and data stable until its handshake; the arbiter never drops a pending request.
REQ-025 Latency: handshake at edge N -> wr_en=1, wr_addr=rd, wr_data=data during cycle N+1; wr_en=0 in every cycle not following a handshake.
REQ-026 When wr_en=0, wr_addr and wr_data hold their last values.
REQ-027 Handshake with rd=0 completes normally (ready=1) but produces wr_en=0 in the following cycle; x0 is never written.
REQ-028 Scoreboard set: rsv_en=1 at an edge with rsv_rd!=0 sets busy[rsv_rd] at that edge.
REQ-029 Scoreboard clear: a handshake with rd!=0 clears busy[rd] at the same edge.
REQ-030 Same-edge set and clear of the same register: set wins (busy stays 1; new reservation).
REQ-031 Same-edge reservation and clear of different registers: both take effect.
REQ-032 busy[0] is constantly 0; rsv_en with rsv_rd=0 has no effect.
REQ-033 Handshake to a register whose busy bit is 0 is legal and still writes; busy remains 0.
REQ-034 Sustained contention: with both valids held high, grants alternate every cycle; neither requester waits more than one cycle.

Reset
REQ-035 rst=0: wr_en=0, wr_addr=0, wr_data=0, busy=all 0, last-granted=LSU (ALU wins the first contention), asynchronously.
REQ-036 rst asserted mid-operation: a write registered but not yet presented is discarded (wr_en forced 0); pending requests are not remembered.
REQ-037 While rst=0, alu_ready=lsu_ready=0 and rsv_en is ignored.
REQ-038 First edge after rst deasserts behaves per REQ-021..REQ-032 with no extra idle cycle.

Verification
REQ-039 Single request: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF -> alu_ready=1 same cycle; next cycle wr_en=1, wr_addr=5, wr_data=0xDEADBEEF.
REQ-040 Contention after reset: both valid (alu_rd=3, lsu_rd=4) held -> ALU granted first, LSU next cycle; writes to 3 then 4 on consecutive cycles.
REQ-041 Scoreboard: rsv_en rsv_rd=7 -> busy[7]=1; lsu write rd=7 -> busy[7]=0 after that edge; simultaneous rsv rd=7 and write rd=7 -> busy[7]=1.
REQ-042 x0: alu write rd=0, data=0xFFFFFFFF -> alu_ready=1, wr_en stays 0; rsv_en rsv_rd=0 -> busy unchanged, busy[0]=0.
REQ-043 Reset mid-flight: handshake at edge N, rst=0 before edge N+1 -> wr_en=0, busy=0 immediately; readies 0 while rst=0.
REQ-044 Random soak (10000 cycles, random valids/rd/data/rsv): at most one ready per cycle, no request starved >1 cycle, wr_en never with wr_addr=0, busy matches reference model.

Source files
------------

// File: rtl/reg_write_arbiter.sv
// Two-requester (ALU / load unit) register-file write arbiter with round-robin
// priority, one registered write port and a per-register pending-write scoreboard.
module reg_write_arbiter #(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 32,
  localparam int AW      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alu_valid,
  output logic                alu_ready,
  input  logic [AW-1:0]       alu_rd,
  input  logic [WIDTH-1:0]    alu_data,
  input  logic                lsu_valid,
  output logic                lsu_ready,
  input  logic [AW-1:0]       lsu_rd,
  input  logic [WIDTH-1:0]    lsu_data,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_rd,
  output logic [NUM_REGS-1:0] busy,
  output logic                wr_en,
  output logic [AW-1:0]       wr_addr,
  output logic [WIDTH-1:0]    wr_data
);

  logic             last_lsu_reg;
  logic             last_lsu_next;
  logic             hs_alu;
  logic             hs_lsu;
  logic             hs_any;
  logic             wr_go;
  logic [AW-1:0]    sel_rd;
  logic [WIDTH-1:0] sel_data;

  logic             wr_en_reg;
  logic [AW-1:0]    wr_addr_reg;
  logic [WIDTH-1:0] wr_data_reg;

  // Grant logic: a lone requester wins outright; under contention the side
  // that did not win the last handshake goes next.
  always_comb begin
    alu_ready = 1'b0;
    lsu_ready = 1'b0;
    if (rst) begin
      alu_ready = alu_valid && (!lsu_valid || last_lsu_reg);
      lsu_ready = lsu_valid && (!alu_valid || !last_lsu_reg);
    end
  end

  always_comb begin
    hs_alu        = alu_valid && alu_ready;
    hs_lsu        = lsu_valid && lsu_ready;
    hs_any        = hs_alu || hs_lsu;
    sel_rd        = hs_lsu ? lsu_rd : alu_rd;
    sel_data      = hs_lsu ? lsu_data : alu_data;
    last_lsu_next = hs_any ? hs_lsu : last_lsu_reg;
    // x0 handshakes complete but never reach the register file.
    wr_go         = hs_any && (sel_rd != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_lsu_reg <= 1'b1;
      wr_en_reg    <= 1'b0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
    end else begin
      last_lsu_reg <= last_lsu_next;
      wr_en_reg    <= wr_go;
      if (wr_go) begin
        wr_addr_reg <= sel_rd;
        wr_data_reg <= sel_data;
      end
    end
  end

  assign wr_en   = wr_en_reg;
  assign wr_addr = wr_addr_reg;
  assign wr_data = wr_data_reg;

  // Scoreboard: bit 0 is hard-wired clear; on a same-edge set/clear the new
  // reservation wins because it describes a younger instruction.
  logic [NUM_REGS-1:0] busy_bits;
  assign busy_bits[0] = 1'b0;

  generate
    for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_busy
      logic set_hit;
      logic clr_hit;
      logic busy_reg;

      assign set_hit = rsv_en && (rsv_rd == AW'(gi));
      assign clr_hit = wr_go && (sel_rd == AW'(gi));

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          busy_reg <= 1'b0;
        end else if (set_hit) begin
          busy_reg <= 1'b1;
        end else if (clr_hit) begin
          busy_reg <= 1'b0;
        end
      end

      assign busy_bits[gi] = busy_reg;
    end
  endgenerate

  assign busy = busy_bits;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: directed scenarios followed by a
// randomized soak compared against a transaction-level reference model.
module tb_reg_write_arbiter;

  localparam int WIDTH    = 32;
  localparam int NUM_REGS = 32;
  localparam int AW       = 5;

  logic                clk;
  logic                rst;
  logic                alu_valid;
  logic                alu_ready;
  logic [AW-1:0]       alu_rd;
  logic [WIDTH-1:0]    alu_data;
  logic                lsu_valid;
  logic                lsu_ready;
  logic [AW-1:0]       lsu_rd;
  logic [WIDTH-1:0]    lsu_data;
  logic                rsv_en;
  logic [AW-1:0]       rsv_rd;
  logic [NUM_REGS-1:0] busy;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [WIDTH-1:0]    wr_data;

  reg_write_arbiter #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS)) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .rsv_en    (rsv_en),
    .rsv_rd    (rsv_rd),
    .busy      (busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: who won last, what the scoreboard holds, what write is due.
  typedef enum int {WHO_ALU, WHO_LSU} who_t;
  who_t                m_last;
  logic [NUM_REGS-1:0] m_busy;
  logic                m_wr_en;
  logic [AW-1:0]       m_addr;
  logic [WIDTH-1:0]    m_data;
  bit                  g_alu;
  bit                  g_lsu;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last  = WHO_LSU;
    m_busy  = '0;
    m_wr_en = 1'b0;
    m_addr  = '0;
    m_data  = '0;
  endtask

  task automatic clear_inputs();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    rsv_en    = 1'b0; rsv_rd = '0;
  endtask

  // Called at a falling edge with inputs already driven; returns at the next
  // falling edge after checking grants before and outputs after the rising edge.
  task automatic cycle();
    logic [AW-1:0]    rd;
    logic [WIDTH-1:0] d;
    #1;
    g_alu = 1'b0;
    g_lsu = 1'b0;
    if (alu_valid && lsu_valid) begin
      if (m_last == WHO_LSU) g_alu = 1'b1;
      else                   g_lsu = 1'b1;
    end else if (alu_valid) begin
      g_alu = 1'b1;
    end else if (lsu_valid) begin
      g_lsu = 1'b1;
    end
    chk("alu_ready", 64'(alu_ready), 64'(g_alu));
    chk("lsu_ready", 64'(lsu_ready), 64'(g_lsu));
    chk("one_ready", 64'(alu_ready && lsu_ready), 64'(0));
    @(posedge clk);
    m_wr_en = 1'b0;
    if (g_alu || g_lsu) begin
      rd     = g_lsu ? lsu_rd : alu_rd;
      d      = g_lsu ? lsu_data : alu_data;
      m_last = g_lsu ? WHO_LSU : WHO_ALU;
      if (rd != 0) begin
        m_wr_en    = 1'b1;
        m_addr     = rd;
        m_data     = d;
        m_busy[rd] = 1'b0;
      end
    end
    if (rsv_en && rsv_rd != 0) m_busy[rsv_rd] = 1'b1;
    #1;
    chk("wr_en", 64'(wr_en), 64'(m_wr_en));
    chk("wr_addr", 64'(wr_addr), 64'(m_addr));
    chk("wr_data", 64'(wr_data), 64'(m_data));
    chk("busy", 64'(busy), 64'(m_busy));
    chk("x0_write", 64'(wr_en && wr_addr == 0), 64'(0));
    @(negedge clk);
  endtask

  // Asserts reset mid-cycle at a falling edge, checks async clearing and that
  // requests/reservations are ignored, then releases reset at a falling edge.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_wr_en", 64'(wr_en), 64'(0));
    chk("rst_wr_addr", 64'(wr_addr), 64'(0));
    chk("rst_wr_data", 64'(wr_data), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    model_reset();
    alu_valid = 1'b1; alu_rd = 5'd6;
    lsu_valid = 1'b1; lsu_rd = 5'd8;
    rsv_en    = 1'b1; rsv_rd = 5'd3;
    #1;
    chk("rst_alu_ready", 64'(alu_ready), 64'(0));
    chk("rst_lsu_ready", 64'(lsu_ready), 64'(0));
    @(posedge clk);
    #1;
    chk("rst_rsv_ignored", 64'(busy), 64'(0));
    chk("rst_hold_wr_en", 64'(wr_en), 64'(0));
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
  endtask

  bit alu_pend;
  bit lsu_pend;
  int alu_wait;
  int lsu_wait;

  initial begin
    clear_inputs();
    model_reset();
    rst = 1'b0;
    #2;
    chk("init_wr_en", 64'(wr_en), 64'(0));
    chk("init_busy", 64'(busy), 64'(0));
    @(negedge clk);
    do_reset();

    // Contention straight out of reset: ALU first, then LSU.
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h0000_0333;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h0000_0444;
    cycle();
    chk("cont_first_alu", 64'(g_alu), 64'(1));
    chk("cont_wr3", 64'(wr_addr), 64'(3));
    alu_valid = 1'b0;
    cycle();
    chk("cont_wr4", 64'(wr_addr), 64'(4));
    chk("cont_wr4_data", 64'(wr_data), 64'(32'h0000_0444));
    clear_inputs();
    cycle();

    // Single ALU request with zero-cycle grant and one-cycle write latency.
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
    cycle();
    chk("single_en", 64'(wr_en), 64'(1));
    chk("single_addr", 64'(wr_addr), 64'(5));
    chk("single_data", 64'(wr_data), 64'(32'hDEAD_BEEF));
    clear_inputs();
    cycle();

    // Scoreboard set, clear, and same-edge set-wins.
    rsv_en = 1'b1; rsv_rd = 5'd7;
    cycle();
    chk("sb_set7", 64'(busy[7]), 64'(1));
    clear_inputs();
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h7777_0001;
    cycle();
    chk("sb_clr7", 64'(busy[7]), 64'(0));
    rsv_en = 1'b1; rsv_rd = 5'd7;
    cycle();
    chk("sb_setwins7", 64'(busy[7]), 64'(1));
    clear_inputs();
    rsv_en = 1'b1; rsv_rd = 5'd9;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h1234_5678;
    cycle();
    chk("sb_diff_clr7", 64'(busy[7]), 64'(0));
    chk("sb_diff_set9", 64'(busy[9]), 64'(1));
    clear_inputs();

    // x0 write and x0 reservation are both no-ops.
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF_FFFF;
    cycle();
    chk("x0_no_write", 64'(wr_en), 64'(0));
    chk("x0_hold_data", 64'(wr_data), 64'(32'h1234_5678));
    clear_inputs();
    rsv_en = 1'b1; rsv_rd = 5'd0;
    cycle();
    chk("x0_busy0", 64'(busy[0]), 64'(0));
    clear_inputs();

    // Reset while a registered write is being presented.
    rsv_en = 1'b1; rsv_rd = 5'd12;
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'hCAFE_F00D;
    cycle();
    chk("midflight_pre_en", 64'(wr_en), 64'(1));
    do_reset();

    // Random soak with held pending requests and occasional resets.
    alu_pend = 1'b0; lsu_pend = 1'b0;
    alu_wait = 0;    lsu_wait = 0;
    for (int i = 0; i < 10000; i++) begin
      if (i % 1999 == 1998) begin
        do_reset();
        alu_pend = 1'b0; lsu_pend = 1'b0;
        alu_wait = 0;    lsu_wait = 0;
      end
      if (!alu_pend) begin
        alu_valid = 1'($urandom_range(0, 1));
        alu_rd    = 5'($urandom_range(0, 31));
        alu_data  = $urandom;
      end
      if (!lsu_pend) begin
        lsu_valid = 1'($urandom_range(0, 1));
        lsu_rd    = 5'($urandom_range(0, 31));
        lsu_data  = $urandom;
      end
      rsv_en = ($urandom_range(0, 2) == 0);
      rsv_rd = 5'($urandom_range(0, 31));
      cycle();
      alu_pend = alu_valid && !g_alu;
      lsu_pend = lsu_valid && !g_lsu;
      alu_wait = alu_pend ? alu_wait + 1 : 0;
      lsu_wait = lsu_pend ? lsu_wait + 1 : 0;
      chk("alu_starve", 64'(alu_wait <= 1), 64'(1));
      chk("lsu_starve", 64'(lsu_wait <= 1), 64'(1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
